input_conditioner: RTL and testbench

- Front-end stage feeding the board top level: takes raw asynchronous slide-switch and push-button pins and produces synchronized, debounced levels plus single-cycle event pulses.
- Its outputs drive the top-level SW/KEY-derived controls: data-memory IO address, source select, and user strobes.
- Removes metastability and contact bounce so downstream logic sees one clean transition per physical action.

---
 rtl/input_cond_pkg.sv | 10 +
 rtl/debounce_bit.sv | 53 +++++
 rtl/input_conditioner.sv | 65 ++++++
 tb/tb_input_conditioner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// input_cond_pkg: shared reset levels and default debounce timing for input_conditioner
// Holds the reset level of each channel type, the system clock rate, and the default
// debounce length derived from it (10 ms), together with a counter width that covers it.
package input_cond_pkg;
    localparam logic SW_RESET_LEVEL  = 1'b0;
    localparam logic KEY_RESET_LEVEL = 1'b1;
    localparam int   CLK_HZ          = 50_000_000;
    localparam int   DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
    localparam int   CNT_W_DEFAULT   = 24;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one synchronized, debounced input channel with update strobes
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_raw       raw asynchronous pin
//   o_stable    debounced level (RESET_LEVEL while in reset)
//   o_rise      1-cycle pulse in the cycle o_stable becomes 1
//   o_fall      1-cycle pulse in the cycle o_stable becomes 0
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter logic RESET_LEVEL     = SW_RESET_LEVEL,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int   CNT_W           = CNT_W_DEFAULT
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    logic             r_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             w_done;

    // The synchronized level has differed from the stable level long enough to be accepted.
    assign w_done = (r_sync != o_stable) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta   <= RESET_LEVEL;
            r_sync   <= RESET_LEVEL;
            o_stable <= RESET_LEVEL;
            r_cnt    <= '0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            o_rise <= w_done & r_sync;
            o_fall <= w_done & ~r_sync;
            if (r_sync == o_stable) begin
                r_cnt <= '0;
            end else if (w_done) begin
                o_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces slide switches and push buttons
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   sw_raw       raw switch pins;  sw_stable  debounced levels;  sw_toggle  pulse per accepted change
//   key_raw      raw buttons (active-low);  key_stable  debounced levels (active-low)
//   key_press    pulse on accepted press (1->0);  key_release  pulse on accepted release (0->1)
//   any_change   OR of all sw_toggle and key_press bits
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_SW            = 9,
    parameter int N_KEY           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SW-1:0]  sw_raw,
    input  logic [N_KEY-1:0] key_raw,
    output logic [N_SW-1:0]  sw_stable,
    output logic [N_KEY-1:0] key_stable,
    output logic [N_SW-1:0]  sw_toggle,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic             any_change
);
    logic [N_SW-1:0] w_sw_rise;
    logic [N_SW-1:0] w_sw_fall;

    genvar g;
    generate
        for (g = 0; g < N_SW; g++) begin : g_sw
            debounce_bit #(
                .RESET_LEVEL    (SW_RESET_LEVEL),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_raw   (sw_raw[g]),
                .o_stable(sw_stable[g]),
                .o_rise  (w_sw_rise[g]),
                .o_fall  (w_sw_fall[g])
            );
        end
        // Buttons are active-low: a falling level is a press, a rising level a release.
        for (g = 0; g < N_KEY; g++) begin : g_key
            debounce_bit #(
                .RESET_LEVEL    (KEY_RESET_LEVEL),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_db (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_raw   (key_raw[g]),
                .o_stable(key_stable[g]),
                .o_rise  (key_release[g]),
                .o_fall  (key_press[g])
            );
        end
    endgenerate

    assign sw_toggle  = w_sw_rise | w_sw_fall;
    assign any_change = (|sw_toggle) | (|key_press);
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner with a sample-history reference model
module tb_input_conditioner;
    localparam int D  = 4;
    localparam int NS = 9;
    localparam int NK = 4;
    localparam int NB = NS + NK;
    localparam logic [NB-1:0] RST_LVL = {{NK{1'b1}}, {NS{1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NS-1:0] sw_raw = '1;
    logic [NK-1:0] key_raw = '0;
    logic [NS-1:0] sw_stable, sw_toggle;
    logic [NK-1:0] key_stable, key_press, key_release;
    logic          any_change;

    input_conditioner #(.N_SW(NS), .N_KEY(NK), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .key_raw(key_raw),
        .sw_stable(sw_stable), .key_stable(key_stable), .sw_toggle(sw_toggle),
        .key_press(key_press), .key_release(key_release), .any_change(any_change)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NS-1:0] st, tg;
        logic [NK-1:0] ks, kp, kr;
        logic          any;
    } exp_t;

    exp_t          exp_q[$];
    logic [NB-1:0] samp[$];
    logic [NB-1:0] mst;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: pins sampled on each edge; a bit's accepted level flips at edge t when the
    // pin samples of edges t-D-1 .. t-2 all disagree with the currently accepted level.
    task automatic model_reset();
        samp.delete();
        repeat (D + 2) samp.push_back(RST_LVL);
        mst = RST_LVL;
    endtask

    task automatic step(input logic [NS-1:0] s, input logic [NK-1:0] k);
        logic [NB-1:0] chg, nx;
        bit            all_diff;
        exp_t          e;
        sw_raw  = s;
        key_raw = k;
        samp.push_back({k, s});
        if (samp.size() > D + 2) void'(samp.pop_front());
        chg = '0;
        for (int b = 0; b < NB; b++) begin
            all_diff = 1'b1;
            for (int j = 3; j <= D + 2; j++)
                if (samp[samp.size() - j][b] == mst[b]) all_diff = 1'b0;
            chg[b] = all_diff;
        end
        nx = mst ^ chg;
        if (chg != '0) begin
            e.cyc = cyc + 1;
            e.st  = nx[NS-1:0];
            e.tg  = chg[NS-1:0];
            e.ks  = nx[NB-1:NS];
            e.kp  = chg[NB-1:NS] & ~nx[NB-1:NS];
            e.kr  = chg[NB-1:NS] & nx[NB-1:NS];
            e.any = (|e.tg) | (|e.kp);
            exp_q.push_back(e);
        end
        mst = nx;
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(sw_raw, key_raw);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) @(negedge clk);
        chk("rst_sw_stable", 32'(sw_stable), 32'h0);
        chk("rst_key_stable", 32'(key_stable), 32'hF);
        chk("rst_pulses", 32'({any_change, key_release, key_press, sw_toggle}), 32'h0);
        rst_n = 1'b1;
    endtask

    // Monitor: whenever the DUT shows pulses (or one is due) compare against the queue head.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_event_cycle", 32'(cyc), 32'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                chk("ev_sw_stable", 32'(sw_stable), 32'(exp_q[0].st));
                chk("ev_sw_toggle", 32'(sw_toggle), 32'(exp_q[0].tg));
                chk("ev_key_stable", 32'(key_stable), 32'(exp_q[0].ks));
                chk("ev_key_press", 32'(key_press), 32'(exp_q[0].kp));
                chk("ev_key_release", 32'(key_release), 32'(exp_q[0].kr));
                chk("ev_any_change", 32'(any_change), 32'(exp_q[0].any));
                void'(exp_q.pop_front());
            end else begin
                chk("no_pulse", 32'({any_change, key_release, key_press, sw_toggle}), 32'h0);
                chk("idle_stable", 32'({key_stable, sw_stable}), 32'(mst));
            end
        end
    end

    initial begin
        logic [NS-1:0] s;
        logic [NK-1:0] k;
        logic [NB-1:0] flip;
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        do_reset(2);

        // Reset release with switches high and buttons held pressed
        hold(5);
        chk("rel_e5_sw_stable", 32'(sw_stable), 32'h0);
        chk("rel_e5_key_stable", 32'(key_stable), 32'hF);
        hold(1);
        chk("rel_e6_sw_stable", 32'(sw_stable), 32'h1FF);
        chk("rel_e6_sw_toggle", 32'(sw_toggle), 32'h1FF);
        chk("rel_e6_key_press", 32'(key_press), 32'hF);
        hold(1);
        chk("rel_e7_sw_toggle", 32'(sw_toggle), 32'h0);
        chk("rel_e7_key_press", 32'(key_press), 32'h0);

        // Return to idle, then a clean switch change
        step('0, '1);
        hold(9);
        step(9'h008, '1);
        hold(4);
        chk("clean_e5_sw3", 32'(sw_stable[3]), 32'h0);
        hold(1);
        chk("clean_e6_sw3", 32'(sw_stable[3]), 32'h1);
        chk("clean_e6_toggle", 32'(sw_toggle), 32'h008);
        chk("clean_e6_any", 32'(any_change), 32'h1);
        hold(1);
        chk("clean_e7_any", 32'(any_change), 32'h0);

        // Bouncing button 0, then a steady press and a steady release
        for (int p = 0; p < 4; p++) begin
            step(sw_raw, {3'b111, ((p % 2) == 0) ? 1'b1 : 1'b0});
            hold(1);
        end
        chk("bounce_key0_held", 32'(key_stable[0]), 32'h1);
        hold(8);
        chk("bounce_key0_pressed", 32'(key_stable[0]), 32'h0);
        step(sw_raw, 4'hF);
        hold(8);
        chk("bounce_key0_released", 32'(key_stable[0]), 32'h1);

        // Short glitch on switch 8
        step(sw_raw | 9'h100, key_raw);
        hold(2);
        step(sw_raw & 9'h0FF, key_raw);
        hold(8);
        chk("glitch_sw8", 32'(sw_stable[8]), 32'h0);

        // Simultaneous switch 0 and key 2 change
        step(sw_raw | 9'h001, 4'b1011);
        hold(4);
        chk("simul_e5_sw0", 32'(sw_stable[0]), 32'h0);
        hold(1);
        chk("simul_e6_toggle", 32'(sw_toggle), 32'h001);
        chk("simul_e6_press", 32'(key_press), 32'h4);
        chk("simul_e6_any", 32'(any_change), 32'h1);
        hold(1);
        chk("simul_e7_any", 32'(any_change), 32'h0);

        // Reset in the middle of a count on switch 1
        step(sw_raw | 9'h002, key_raw);
        hold(2);
        do_reset(2);
        chk("midrst_sw1_release", 32'(sw_stable[1]), 32'h0);
        hold(5);
        chk("midrst_e5_sw1", 32'(sw_stable[1]), 32'h0);
        hold(1);
        chk("midrst_e6_sw1", 32'(sw_stable[1]), 32'h1);
        chk("midrst_e6_toggle", 32'(sw_toggle), 32'h00B);
        hold(8);

        // Randomized bouncing on all channels
        for (int r = 0; r < 120; r++) begin
            flip = NB'($urandom) & NB'($urandom) & NB'($urandom);
            s = sw_raw ^ flip[NS-1:0];
            k = key_raw ^ flip[NB-1:NS];
            step(s, k);
            hold(int'($urandom_range(0, 6)));
        end
        hold(10);
        chk("final_stable", 32'({key_stable, sw_stable}), 32'({key_raw, sw_raw}));
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
